inst_loader: RTL and testbench



---
 rtl/inst_loader.sv | 191 +++++++++++++++++++
 tb/tb_inst_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: turns a UART byte stream (4-byte big-endian word count,
// then MSB-first 32-bit words) into instruction-memory writes at 0, 1, 2, ...
// and reports done/error to the core control.
module inst_loader #(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [31:0]           hdr_q, hdr_d;
  logic [23:0]           word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic [1:0]            err_q, err_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  in_busy;
  logic                  finish;
  logic                  tmo_hit;
  logic [31:0]           hdr_next;

  // State and datapath registers; reset drops straight back to IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      bidx_q  <= '0;
      hdr_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wl_q    <= '0;
      err_q   <= ERR_NONE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      hdr_q   <= hdr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wl_q    <= wl_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: header parse, word assembly, write issue, timeout.
  always_comb begin
    state_d  = state_q;
    bidx_d   = bidx_q;
    hdr_d    = hdr_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wl_d     = wl_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    hdr_next = {hdr_q[23:0], rx_data};

    in_busy  = (state_q == S_HEADER) || (state_q == S_LOAD);
    // The write cycle that completes the N-th word ends the load.
    finish   = we_q && ((32'(wl_q) + 32'd1) == hdr_q);

    tmo_hit  = 1'b0;
    if ((TIMEOUT_CYCLES != 0) && in_busy) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else begin
        tmo_d   = tmo_q + TW'(1);
        tmo_hit = (32'(tmo_q) + 32'd1) == TIMEOUT_CYCLES;
      end
    end

    if (abort) begin
      state_d = S_IDLE;
      err_d   = ERR_NONE;
      we_d    = 1'b0;
      bidx_d  = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_d = S_HEADER;
            wl_d    = '0;
            err_d   = ERR_NONE;
            bidx_d  = '0;
            addr_d  = '0;
            tmo_d   = '0;
            hdr_d   = '0;
          end
        end

        S_HEADER: begin
          if (rx_valid) begin
            hdr_d  = hdr_next;
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              if (hdr_next == 32'd0) begin
                state_d = S_DONE;
              end else if (hdr_next > DEPTH) begin
                state_d = S_ERROR;
                err_d   = ERR_OVERFLOW;
              end else begin
                state_d = S_LOAD;
              end
            end
          end else if (tmo_hit) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
            bidx_d  = '0;
          end
        end

        S_LOAD: begin
          if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            wl_d   = wl_q + (ADDR_WIDTH + 1)'(1);
          end
          // A byte in a write cycle is folded into the next word, except
          // on the final write where nothing more belongs to this load.
          if (finish) begin
            state_d = S_DONE;
          end else if (rx_valid) begin
            word_d = {word_q[15:0], rx_data};
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              we_d    = 1'b1;
              wdata_d = {word_q, rx_data};
            end
          end else if (tmo_hit) begin
            state_d = S_ERROR;
            err_d   = ERR_TIMEOUT;
            bidx_d  = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; an abort in a write cycle suppresses that write.
  always_comb begin
    mem_we       = we_q && !abort;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    busy         = (state_q == S_HEADER) || (state_q == S_LOAD);
    done         = (state_q == S_DONE);
    error        = (state_q == S_ERROR);
    err_code     = err_q;
    words_loaded = wl_q;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (ADDR_WIDTH=2, TIMEOUT_CYCLES=16).
// Inputs change 1 ns after a rising edge; writes are logged on falling edges.
module tb_inst_loader;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [2:0]  words_loaded;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [1:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  inst_loader #(
    .ADDR_WIDTH     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .abort        (abort),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(2);
    total_cnt++;
    if ({busy, done, error, mem_we} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, mem_we});
    else pass_cnt++;
    total_cnt++;
    if (err_code !== 2'b00) $display("FAIL reset_err_code: got %b expected 00", err_code);
    else pass_cnt++;
    total_cnt++;
    if (words_loaded !== 3'd0) $display("FAIL reset_words: got %0d expected 0", words_loaded);
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 2'd0) $display("FAIL reset_addr: got %0d expected 0", mem_addr);
    else pass_cnt++;
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int unsigned base = wr_addr.size();
    pulse_start();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy);
    else pass_cnt++;
    put(8'h00); put(8'h00); put(8'h00); put(8'h02);
    put(8'h20); put(8'h01); put(8'h00); put(8'h05);
    put(8'hF0); put(8'h20); put(8'h00); put(8'h00);
    tick(1);
    total_cnt++;
    if (wr_addr.size() - base !== 2) $display("FAIL basic_nwrites: got %0d expected 2", wr_addr.size() - base);
    else pass_cnt++;
    if (wr_addr.size() - base == 2) begin
      total_cnt++;
      if ({wr_addr[base], wr_data[base]} !== {2'd0, 32'h20010005})
        $display("FAIL basic_w0: got addr %0d data %h expected addr 0 data 20010005", wr_addr[base], wr_data[base]);
      else pass_cnt++;
      total_cnt++;
      if ({wr_addr[base+1], wr_data[base+1]} !== {2'd1, 32'hF0200000})
        $display("FAIL basic_w1: got addr %0d data %h expected addr 1 data f0200000", wr_addr[base+1], wr_data[base+1]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({done, busy, error} !== 3'b100) $display("FAIL basic_done: got done/busy/error %b expected 100", {done, busy, error});
    else pass_cnt++;
    total_cnt++;
    if (words_loaded !== 3'd2) $display("FAIL basic_words: got %0d expected 2", words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00); put(8'h05);
    total_cnt++;
    if ({error, err_code} !== 3'b101) $display("FAIL ovf_error: got error %b code %b expected 1 01", error, err_code);
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if (wr_addr.size() !== base) $display("FAIL ovf_nowrite: got %0d writes expected 0", wr_addr.size() - base);
    else pass_cnt++;
    pulse_start();
    total_cnt++;
    if ({busy, error, err_code} !== 4'b1000) $display("FAIL ovf_restart: got busy/error/code %b expected 1000", {busy, error, err_code});
    else pass_cnt++;
    put(8'h00); put(8'h00); put(8'h00); put(8'h01);
    put(8'h12); put(8'h34); put(8'h56); put(8'h78);
    tick(1);
    total_cnt++;
    if (wr_addr.size() - base !== 1) $display("FAIL ovf_reload_nwrites: got %0d expected 1", wr_addr.size() - base);
    else pass_cnt++;
    if (wr_addr.size() - base == 1) begin
      total_cnt++;
      if ({wr_addr[base], wr_data[base]} !== {2'd0, 32'h12345678})
        $display("FAIL ovf_reload_w0: got addr %0d data %h expected addr 0 data 12345678", wr_addr[base], wr_data[base]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({done, words_loaded} !== {1'b1, 3'd1}) $display("FAIL ovf_reload_done: got done %b words %0d expected 1 1", done, words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL zero_early: got done %b expected 0", done);
    else pass_cnt++;
    put(8'h00);
    total_cnt++;
    if ({done, busy, words_loaded} !== {2'b10, 3'd0}) $display("FAIL zero_done: got done/busy %b words %0d expected 10 0", {done, busy}, words_loaded);
    else pass_cnt++;
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
    tick(1);
    total_cnt++;
    if (wr_addr.size() !== base) $display("FAIL zero_nowrite: got %0d writes expected 0", wr_addr.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00); put(8'h01);
    put(8'hAA); put(8'hBB);
    tick(15);
    total_cnt++;
    if ({busy, error} !== 2'b10) $display("FAIL tmo_early: got busy/error %b expected 10", {busy, error});
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({error, err_code} !== 3'b110) $display("FAIL tmo_error: got error %b code %b expected 1 10", error, err_code);
    else pass_cnt++;
    put(8'hCC); put(8'hDD); tick(2);
    total_cnt++;
    if ({wr_addr.size() - base, words_loaded} !== {32'd0, 3'd0})
      $display("FAIL tmo_nowrite: got %0d writes words %0d expected 0 0", wr_addr.size() - base, words_loaded);
    else pass_cnt++;
    total_cnt++;
    if ({error, err_code} !== 3'b110) $display("FAIL tmo_hold: got error %b code %b expected 1 10", error, err_code);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int unsigned base = wr_addr.size();
    logic [31:0] exp_w[4];
    exp_w[0] = 32'h00010203; exp_w[1] = 32'h04050607;
    exp_w[2] = 32'h08090A0B; exp_w[3] = 32'h0C0D0E0F;
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00); put(8'h04);
    for (int unsigned i = 0; i < 16; i++) put(8'(i));
    tick(1);
    total_cnt++;
    if (wr_addr.size() - base !== 4) $display("FAIL b2b_nwrites: got %0d expected 4", wr_addr.size() - base);
    else pass_cnt++;
    if (wr_addr.size() - base == 4) begin
      for (int unsigned i = 0; i < 4; i++) begin
        total_cnt++;
        if ({wr_addr[base+i], wr_data[base+i]} !== {2'(i), exp_w[i]})
          $display("FAIL b2b_w%0d: got addr %0d data %h expected addr %0d data %h", i, wr_addr[base+i], wr_data[base+i], i, exp_w[i]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({done, words_loaded, mem_addr, mem_we} !== {1'b1, 3'd4, 2'd0, 1'b0})
      $display("FAIL b2b_done: got done %b words %0d addr %0d we %b expected 1 4 0 0", done, words_loaded, mem_addr, mem_we);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00); put(8'h02);
    put(8'h11); put(8'h22); put(8'h33);
    pulse_abort();
    total_cnt++;
    if ({busy, done, error} !== 3'b000) $display("FAIL abort_idle: got busy/done/error %b expected 000", {busy, done, error});
    else pass_cnt++;
    put(8'h44); put(8'h55); put(8'h66); put(8'h77); put(8'h88);
    tick(2);
    total_cnt++;
    if (wr_addr.size() !== base) $display("FAIL abort_nowrite: got %0d writes expected 0", wr_addr.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00); put(8'h02);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h55); put(8'h66);
    RST_N = 1'b0;
    #2;
    total_cnt++;
    if ({busy, mem_we, words_loaded} !== {2'b00, 3'd0}) $display("FAIL rst_mid_idle: got busy/we %b words %0d expected 00 0", {busy, mem_we}, words_loaded);
    else pass_cnt++;
    tick(1);
    RST_N = 1'b1;
    put(8'h77); put(8'h88); put(8'h99); put(8'hAA);
    tick(2);
    total_cnt++;
    if (wr_addr.size() - base !== 1) $display("FAIL rst_mid_nwrites: got %0d expected 1", wr_addr.size() - base);
    else pass_cnt++;
    if (wr_addr.size() - base == 1) begin
      total_cnt++;
      if ({wr_addr[base], wr_data[base]} !== {2'd0, 32'h11223344})
        $display("FAIL rst_mid_w0: got addr %0d data %h expected addr 0 data 11223344", wr_addr[base], wr_data[base]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    int unsigned base = wr_addr.size();
    pulse_start();
    put(8'h00); put(8'h00);
    pulse_start();
    put(8'h00); put(8'h03);
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    pulse_start();
    put(8'h05); put(8'h06);
    pulse_start();
    put(8'h07); put(8'h08);
    put(8'h09); put(8'h0A); put(8'h0B); put(8'h0C);
    tick(1);
    total_cnt++;
    if (wr_addr.size() - base !== 3) $display("FAIL start_ign_nwrites: got %0d expected 3", wr_addr.size() - base);
    else pass_cnt++;
    if (wr_addr.size() - base == 3) begin
      total_cnt++;
      if ({wr_addr[base], wr_addr[base+1], wr_addr[base+2]} !== {2'd0, 2'd1, 2'd2})
        $display("FAIL start_ign_addrs: got %0d %0d %0d expected 0 1 2", wr_addr[base], wr_addr[base+1], wr_addr[base+2]);
      else pass_cnt++;
      total_cnt++;
      if ({wr_data[base], wr_data[base+1], wr_data[base+2]} !== {32'h01020304, 32'h05060708, 32'h090A0B0C})
        $display("FAIL start_ign_data: got %h %h %h expected 01020304 05060708 090a0b0c", wr_data[base], wr_data[base+1], wr_data[base+2]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({done, words_loaded} !== {1'b1, 3'd3}) $display("FAIL start_ign_done: got done %b words %0d expected 1 3", done, words_loaded);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    RST_N     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_midload();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
